// File: rtl/player_pkg.sv
// Shared types and default parameters for the I2S DAC player.
// Holds the serialiser state encoding and the default sample width and MSB delay.
package player_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DELAY_DEF = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SHIFT,
    S_PAD
  } ser_state_e;

endpackage

// File: rtl/i2s_dac_player_if.sv
// Sample input, codec LR clock and DAC-side outputs of the I2S DAC player.
// The master modport drives the inputs; the player uses the slave modport.
interface i2s_dac_player_if
  import player_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             i_daclrck;
  logic [WIDTH-1:0] i_data;
  logic             i_done;
  logic             o_aud_dacdat;
  logic             o_underrun;
  logic             o_overrun;

  modport master (
    output i_daclrck, i_data, i_done,
    input  o_aud_dacdat, o_underrun, o_overrun
  );

  modport slave (
    input  i_daclrck, i_data, i_done,
    output o_aud_dacdat, o_underrun, o_overrun
  );

endinterface

// File: rtl/i2s_serializer.sv
// MSB-first word serialiser for one LR half-frame.
// It restarts on every frame edge, so a short frame simply truncates the word.
module i2s_serializer
  import player_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DELAY = DELAY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_edge,
  input  logic [WIDTH-1:0] load_value,
  output logic             dacdat
);

  localparam int unsigned CNT_MAX = (WIDTH > DELAY) ? WIDTH : DELAY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic             dout_q, dout_n;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
      dout_q  <= dout_n;
    end
  end

  // Next state: any edge restarts the word
  always_comb begin
    state_n = state_q;
    if (frame_edge) begin
      state_n = (DELAY == 0) ? S_SHIFT : S_DELAY;
    end else begin
      case (state_q)
        S_DELAY: if (cnt_q == DLY_LAST) state_n = S_SHIFT;
        S_SHIFT: if (cnt_q == BIT_LAST) state_n = S_PAD;
        default: ;
      endcase
    end
  end

  // Counter, shifter and next output bit; counter tracks the bit currently on the wire
  always_comb begin
    cnt_n  = cnt_q;
    sh_n   = sh_q;
    dout_n = 1'b0;
    if (frame_edge) begin
      cnt_n = '0;
      if (DELAY == 0) begin
        dout_n = load_value[WIDTH-1];
        sh_n   = load_value << 1;
      end else begin
        sh_n = load_value;
      end
    end else begin
      case (state_q)
        S_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            dout_n = sh_q[WIDTH-1];
            sh_n   = sh_q << 1;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (cnt_q != BIT_LAST) begin
            dout_n = sh_q[WIDTH-1];
            sh_n   = sh_q << 1;
            cnt_n  = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dacdat = dout_q;

endmodule

// File: rtl/i2s_dac_player.sv
// I2S DAC player: single-entry sample buffer, LRCK edge detect and flags around the serialiser.
// Build option PLAYER_UNDERRUN_MUTE_EN mutes an underrun frame instead of repeating the last sample.
module i2s_dac_player
  import player_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DELAY = DELAY_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  i2s_dac_player_if.slave  bus
);

  logic             lrck_r;
  logic [WIDTH-1:0] buf_r;
  logic             valid_r;
  logic [WIDTH-1:0] play_r;
  logic [WIDTH-1:0] play_next;
  logic             underrun_r;
  logic             overrun_r;
  logic             frame_edge;
  logic             left_edge;

  assign frame_edge = (bus.i_daclrck != lrck_r);
  assign left_edge  = frame_edge & ~bus.i_daclrck;

  // Value play_r takes at this edge; the serialiser loads it directly
  always_comb begin
    play_next = play_r;
    if (left_edge) begin
      if (valid_r) begin
        play_next = buf_r;
      end else begin
`ifdef PLAYER_UNDERRUN_MUTE_EN
        play_next = '0;
`else
        play_next = play_r;
`endif
      end
    end
  end

  // Buffer, playback word, LRCK history and status pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lrck_r     <= 1'b0;
      buf_r      <= '0;
      valid_r    <= 1'b0;
      play_r     <= '0;
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      lrck_r     <= bus.i_daclrck;
      play_r     <= play_next;
      underrun_r <= left_edge & ~valid_r;
      overrun_r  <= bus.i_done & valid_r & ~left_edge;
      if (bus.i_done) begin
        buf_r   <= bus.i_data;
        valid_r <= 1'b1;
      end else if (left_edge) begin
        valid_r <= 1'b0;
      end
    end
  end

  i2s_serializer #(
    .WIDTH (WIDTH),
    .DELAY (DELAY)
  ) u_ser (
    .clk        (i_clk),
    .rst        (i_rst),
    .frame_edge (frame_edge),
    .load_value (play_next),
    .dacdat     (bus.o_aud_dacdat)
  );

  assign bus.o_underrun = underrun_r;
  assign bus.o_overrun  = overrun_r;

endmodule
